// File: rtl/syn_gpu_pkg.sv
// Shared GPU-subsystem types: bus master IDs and the mulberry divider FSM states.
package syn_gpu_pkg;

   typedef enum logic [2:0] {
      MID_IDLE     = 3'd0,
      MID_GPU_CORE = 3'd1,
      MID_GPU_LB   = 3'd2,
      MID_GPU_TEX  = 3'd3,
      MID_HOST     = 3'd4
   } mid_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_fsm_t;

endpackage

// File: rtl/mulberry_div.sv
// Mulberry-bus iterative restoring divider, one quotient bit per clock.
// Optional MULBERRY_DIV_SIGNED_EN selects two's-complement operands.
module mulberry_div
   import syn_gpu_pkg::*;
#(
   parameter int P_BUS_DATA_W = 32,
   parameter int P_DIV_W      = P_BUS_DATA_W / 2
) (
   input  logic                    clk_ir,
   input  logic                    rst_ih,
   input  logic [P_BUS_DATA_W-1:0] div_req_data,
   input  mid_t                    div_req_mid,
   output logic                    div_busy,
   output logic [P_BUS_DATA_W-1:0] div_rsp_data,
   output mid_t                    div_rsp_mid
);

   localparam int W     = P_DIV_W;
   localparam int CNT_W = $clog2(P_DIV_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DIV_W - 1);

   div_fsm_t         state_q, state_d;
   logic [W-1:0]     dvd_q;
   logic [W-1:0]     dvs_q;
   logic [W:0]       rem_q;
   logic [CNT_W-1:0] cnt_q;
   mid_t             mid_q;

   logic [W-1:0]     req_dvd, req_dvs;
   logic [W-1:0]     op_dvd, op_dvs;
   logic [W:0]       shifted, rem_nxt;
   logic [W-1:0]     quo_nxt;
   logic [W-1:0]     q_fin, r_fin;
   logic             ge;
   logic             accept, req_dz, step_en, ld_rsp_calc, ld_rsp_dz, clr_rsp;

   assign req_dvd = div_req_data[P_BUS_DATA_W-1:W];
   assign req_dvs = div_req_data[W-1:0];
   assign req_dz  = (req_dvs == '0);

`ifdef MULBERRY_DIV_SIGNED_EN
   logic q_neg_q, r_neg_q;

   function automatic logic [W-1:0] f_mag(input logic signed [W-1:0] v);
      logic [W-1:0] r;
      r = v[W-1] ? -v : v;
      return r;
   endfunction

   function automatic logic [W-1:0] f_apply_sign(input logic [W-1:0] mag, input logic neg);
      logic [W-1:0] r;
      r = neg ? -mag : mag;
      return r;
   endfunction

   assign op_dvd = f_mag(req_dvd);
   assign op_dvs = f_mag(req_dvs);
   assign q_fin  = f_apply_sign(quo_nxt, q_neg_q);
   assign r_fin  = f_apply_sign(rem_nxt[W-1:0], r_neg_q);
`else
   assign op_dvd = req_dvd;
   assign op_dvs = req_dvs;
   assign q_fin  = quo_nxt;
   assign r_fin  = rem_nxt[W-1:0];
`endif

   // Restoring step: shift in next dividend bit, subtract if it fits.
   always_comb begin
      shifted = {rem_q[W-1:0], dvd_q[W-1]};
      ge      = (shifted >= {1'b0, dvs_q});
      rem_nxt = ge ? (shifted - {1'b0, dvs_q}) : shifted;
      quo_nxt = (dvd_q << 1) | W'(ge);
   end

   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = req_dz ? DONE : CALC;
         CALC:    if (cnt_q == CNT_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept      = (state_q == IDLE) && (div_req_mid != MID_IDLE) && !div_busy;
      step_en     = (state_q == CALC);
      ld_rsp_calc = step_en && (cnt_q == CNT_LAST);
      ld_rsp_dz   = accept && req_dz;
      clr_rsp     = (state_q == DONE);
   end

   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
         mid_q <= MID_IDLE;
      end else if (accept) begin
         dvd_q <= op_dvd;
         dvs_q <= op_dvs;
         rem_q <= '0;
         cnt_q <= '0;
         mid_q <= div_req_mid;
      end else if (step_en) begin
         dvd_q <= quo_nxt;
         rem_q <= rem_nxt;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

`ifdef MULBERRY_DIV_SIGNED_EN
   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) begin
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else if (accept) begin
         q_neg_q <= req_dvd[W-1] ^ req_dvs[W-1];
         r_neg_q <= req_dvd[W-1];
      end
   end
`endif

   // Divide-by-zero returns the raw dividend, so it bypasses the sign fixup.
   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) begin
         div_busy     <= 1'b0;
         div_rsp_data <= '0;
         div_rsp_mid  <= MID_IDLE;
      end else begin
         div_busy <= (state_d != IDLE);
         if (ld_rsp_dz) begin
            div_rsp_data <= {{W{1'b1}}, req_dvd};
            div_rsp_mid  <= div_req_mid;
         end else if (ld_rsp_calc) begin
            div_rsp_data <= {q_fin, r_fin};
            div_rsp_mid  <= mid_q;
         end else if (clr_rsp) begin
            div_rsp_data <= '0;
            div_rsp_mid  <= MID_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mulberry_div.sv
// Directed bench for mulberry_div; expectations follow MULBERRY_DIV_SIGNED_EN when defined.
module tb_mulberry_div;
   import syn_gpu_pkg::*;

   logic        clk_ir = 1'b0;
   logic        rst_ih = 1'b1;
   logic [31:0] div_req_data = '0;
   mid_t        div_req_mid = MID_IDLE;
   logic        div_busy;
   logic [31:0] div_rsp_data;
   mid_t        div_rsp_mid;

   int n_chk  = 0;
   int n_pass = 0;

   mulberry_div #(.P_BUS_DATA_W(32)) dut (
      .clk_ir       (clk_ir),
      .rst_ih       (rst_ih),
      .div_req_data (div_req_data),
      .div_req_mid  (div_req_mid),
      .div_busy     (div_busy),
      .div_rsp_data (div_rsp_data),
      .div_rsp_mid  (div_rsp_mid)
   );

   always #5 clk_ir = ~clk_ir;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Issue one request, wait for its response, check latency, payload and release.
   task automatic do_req(input string tag, input mid_t mid, input logic [31:0] data,
                         input logic [31:0] exp_rsp, input int exp_lat);
      int n;
      @(negedge clk_ir);
      div_req_mid  = mid;
      div_req_data = data;
      @(posedge clk_ir); #1;
      div_req_mid  = MID_IDLE;
      div_req_data = 32'hDEAD_BEEF;
      chk({tag, "_busy_rise"}, 64'(div_busy), 64'd1);
      n = 1;
      while (div_rsp_mid == MID_IDLE && n < 60) begin
         @(posedge clk_ir); #1;
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
      chk({tag, "_rsp_data"}, 64'(div_rsp_data), 64'(exp_rsp));
      chk({tag, "_rsp_mid"}, 64'(div_rsp_mid), 64'(mid));
      @(posedge clk_ir); #1;
      chk({tag, "_rsp_clear"}, {32'(div_rsp_mid), div_rsp_data}, 64'd0);
      chk({tag, "_busy_drop"}, 64'(div_busy), 64'd0);
   endtask

   initial begin
      int n_rsp, bad_mid, bad_busy, bad_data;
      logic drop_pending, dropped;
      logic [31:0] rsp_d [2];
      mid_t        rsp_m [2];
      int          rsp_n [2];
      logic [31:0] exp_neg;

      repeat (3) @(posedge clk_ir);
      #1;
      chk("reset_busy", 64'(div_busy), 64'd0);
      chk("reset_rsp_mid", 64'(div_rsp_mid), 64'(MID_IDLE));
      chk("reset_rsp_data", 64'(div_rsp_data), 64'd0);
      @(negedge clk_ir);
      rst_ih = 1'b0;
      repeat (2) @(posedge clk_ir);

      do_req("u100_7", MID_GPU_CORE, 32'h0064_0007, 32'h000E_0002, 17);
      do_req("divz", MID_GPU_CORE, 32'h0005_0000, 32'hFFFF_0005, 1);
      do_req("divz_neg", MID_HOST, 32'hFF9C_0000, 32'hFFFF_FF9C, 1);
      do_req("ones", MID_GPU_TEX, 32'hFFFF_FFFF, 32'h0001_0000, 17);
      do_req("small", MID_GPU_LB, 32'h0003_0008, 32'h0000_0003, 17);
      do_req("min_by1", MID_GPU_CORE, 32'h8000_0001, 32'h8000_0000, 17);
`ifdef MULBERRY_DIV_SIGNED_EN
      exp_neg = 32'hFFF2_FFFE;
`else
      exp_neg = 32'h2484_0000;
`endif
      do_req("neg100_7", MID_GPU_CORE, 32'hFF9C_0007, exp_neg, 17);

      // Back-to-back: second request held on the bus while the first is busy.
      @(negedge clk_ir);
      div_req_mid  = MID_GPU_CORE;
      div_req_data = 32'h0064_0007;
      @(posedge clk_ir); #1;
      div_req_mid  = MID_GPU_LB;
      div_req_data = 32'h0009_0002;
      n_rsp = 0; drop_pending = 1'b0; dropped = 1'b0;
      for (int n = 1; n <= 50; n++) begin
         if (n > 1) begin
            @(posedge clk_ir); #1;
         end
         if (drop_pending && !dropped) begin
            div_req_mid = MID_IDLE;
            dropped = 1'b1;
         end
         if (div_rsp_mid != MID_IDLE) begin
            if (n_rsp < 2) begin
               rsp_d[n_rsp] = div_rsp_data;
               rsp_m[n_rsp] = div_rsp_mid;
               rsp_n[n_rsp] = n;
            end
            n_rsp++;
         end
         if (!div_busy && !drop_pending) drop_pending = 1'b1;
      end
      chk("b2b_count", 64'(n_rsp), 64'd2);
      if (n_rsp >= 2) begin
         chk("b2b_first_data", 64'(rsp_d[0]), 64'h000E_0002);
         chk("b2b_first_mid", 64'(rsp_m[0]), 64'(MID_GPU_CORE));
         chk("b2b_first_cycle", 64'(rsp_n[0]), 64'd17);
         chk("b2b_second_data", 64'(rsp_d[1]), 64'h0004_0001);
         chk("b2b_second_mid", 64'(rsp_m[1]), 64'(MID_GPU_LB));
         chk("b2b_second_cycle", 64'(rsp_n[1]), 64'd35);
      end

      // Reset during CALC cycle 5 discards the transaction.
      @(negedge clk_ir);
      div_req_mid  = MID_GPU_CORE;
      div_req_data = 32'h0064_0007;
      @(posedge clk_ir); #1;
      div_req_mid  = MID_IDLE;
      repeat (4) @(posedge clk_ir);
      #1;
      chk("rst_pre_busy", 64'(div_busy), 64'd1);
      rst_ih = 1'b1;
      #1;
      chk("rst_async_busy", 64'(div_busy), 64'd0);
      chk("rst_async_rsp", {32'(div_rsp_mid), div_rsp_data}, 64'd0);
      @(negedge clk_ir);
      rst_ih = 1'b0;
      bad_mid = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_ir); #1;
         if (div_rsp_mid != MID_IDLE || div_busy) bad_mid++;
      end
      chk("rst_no_rsp", 64'(bad_mid), 64'd0);

      // Idle bus with random data.
      bad_mid = 0; bad_busy = 0; bad_data = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_ir);
         div_req_mid  = MID_IDLE;
         div_req_data = $urandom;
         @(posedge clk_ir); #1;
         if (div_busy) bad_busy++;
         if (div_rsp_mid != MID_IDLE) bad_mid++;
         if (div_rsp_data != 32'd0) bad_data++;
      end
      chk("idle_busy", 64'(bad_busy), 64'd0);
      chk("idle_rsp_mid", 64'(bad_mid), 64'd0);
      chk("idle_rsp_data", 64'(bad_data), 64'd0);

      do_req("post_idle", MID_GPU_LB, 32'h0009_0002, 32'h0004_0001, 17);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mulberry_div.md
MULBERRY_DIV -- requirements
Module: mulberry_div

Interface
REQ-001 Parameter P_BUS_DATA_W, default 32, mulberry bus data width; SHALL be even.
REQ-002 Parameter P_DIV_W, default P_BUS_DATA_W/2, operand width.
REQ-003 clk_ir  in  1  single clock; all state on its rising edge.
REQ-004 rst_ih  in  1  reset, asynchronous and active-high.
REQ-005 div_req_data  in  P_BUS_DATA_W  request operands: dividend [P_BUS_DATA_W-1:P_DIV_W], divisor [P_DIV_W-1:0].
REQ-006 div_req_mid  in  mid_t  requesting master; MID_IDLE means no request.
REQ-007 div_busy  out  1  high while a request is being processed.
REQ-008 div_rsp_data  out  P_BUS_DATA_W  quotient [P_BUS_DATA_W-1:P_DIV_W], remainder [P_DIV_W-1:0].
REQ-009 div_rsp_mid  out  mid_t  master owed the response; MID_IDLE when no response.

Function
REQ-010 FSM states are IDLE, CALC and DONE.
REQ-011 IDLE: a request is accepted on any rising edge where div_req_mid != MID_IDLE and div_busy == 0; the block latches the operands and the mid.
REQ-012 On accept: if divisor != 0, go to CALC with the iteration counter at 0; if divisor == 0, go directly to DONE.
REQ-013 div_busy is registered: 1 in CALC and DONE, 0 in IDLE.
REQ-014 The block ignores div_req_mid and div_req_data whenever div_busy == 1; the bus interconnect drives them regardless.
REQ-015 CALC: restoring division, one quotient bit per cycle, MSB first, over exactly P_DIV_W cycles.
REQ-016 The partial remainder is P_DIV_W+1 bits wide so no subtraction overflows.
REQ-017 When the counter reaches P_DIV_W-1, go to DONE.
REQ-018 div_rsp_data and div_rsp_mid are registers loaded on entry to DONE.
REQ-019 They hold the result and latched mid for exactly one cycle.
REQ-020 Outside DONE: div_rsp_mid = MID_IDLE and div_rsp_data = 0.
REQ-021 DONE always returns to IDLE after one cycle.
REQ-022 A request presented during DONE is not accepted; it is accepted in the following IDLE cycle.
REQ-023 Latency from the accept edge to the first DONE cycle: P_DIV_W+1 cycles for nonzero divisor, 1 cycle for zero divisor.
REQ-024 Divide-by-zero result: quotient = all ones, remainder = dividend.

Reset
REQ-025 While rst_ih = 1: state = IDLE, div_busy = 0, div_rsp_mid = MID_IDLE, div_rsp_data = 0, counter and operand registers = 0.
REQ-026 Reset mid-operation (CALC or DONE) discards the transaction; no response is issued after reset release.

Configuration
REQ-027 Macro MULBERRY_DIV_SIGNED_EN defined: operands are two's complement.
REQ-028 With the macro, magnitudes are taken at accept and the core divides unsigned.
REQ-029 With the macro, quotient sign = XOR of operand signs, and remainder sign follows the dividend; signs are applied when loading the DONE outputs with no added latency.
REQ-030 With the macro, divide-by-zero behaviour per REQ-024 is unchanged.
REQ-031 Macro undefined: unsigned operation only; no sign logic is compiled.

Structure
REQ-032 mid_t and the MID_* constants come from syn_gpu_pkg.
REQ-033 The FSM state enum div_fsm_t (IDLE, CALC, DONE) is added to syn_gpu_pkg.
REQ-034 No sub-module; the single-step subtract/compare is inline combinational logic.

Verification
REQ-035 Unsigned 100/7: req_data 0x0064_0007, mid MID_GPU_CORE.
- div_busy rises the next cycle.
- 17 cycles after accept: rsp 0x000E_0002, mid MID_GPU_CORE, for one cycle.
- Then busy drops.
REQ-036 Divide-by-zero: req_data 0x0005_0000.
- Next cycle: rsp 0xFFFF_0005 for one cycle.
- busy high for exactly 1 cycle.
REQ-037 Back-to-back requests: a second request (MID_GPU_LB, 0x0009_0002) is held during busy.
- It is ignored until IDLE.
- It is then accepted, giving rsp 0x0004_0001, mid MID_GPU_LB.
- Exactly one response per request.
REQ-038 Reset asserted at CALC cycle 5: all outputs return to reset values immediately.
- No rsp_mid != MID_IDLE appears within 40 cycles after release.
REQ-039 Operand 0xFF9C_0007 gives a mode-dependent result:
- Without the macro: rsp 0x2484_0000.
- With MULBERRY_DIV_SIGNED_EN: rsp 0xFFF2_FFFE (-14 remainder -2).
REQ-040 Idle bus: req_mid = MID_IDLE with random req_data for 100 cycles.
- busy stays 0.
- rsp_mid stays MID_IDLE.
- rsp_data stays 0.
